// File: rtl/fact_accel.sv
// Memory-mapped factorial accelerator: software writes N, pulses GO, polls STATUS, reads RESULT.
// n! is built one multiply per clock; an n above MAX_N is rejected with a sticky error flag.
module fact_accel #(
    parameter int N_W   = 4,
    parameter int MAX_N = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [1:0]  a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [1:0]  A_N      = 2'd0;
    localparam logic [1:0]  A_GO     = 2'd1;
    localparam logic [1:0]  A_STATUS = 2'd2;
    localparam logic [1:0]  A_RESULT = 2'd3;
    localparam logic [31:0] MAX_N_32 = 32'(MAX_N);

    state_t         state;
    logic [N_W-1:0] n_reg;
    logic [N_W-1:0] cnt;
    logic [31:0]    acc;
    logic [31:0]    result;
    logic           done;
    logic           err;

    logic go_req;
    logic n_too_big;
    logic wd_unused;

    assign go_req    = we && (a == A_GO) && wd[0];
    assign n_too_big = 32'(n_reg) > MAX_N_32;
    assign wd_unused = ^wd[31:N_W];

    // cnt, not n_reg, drives the loop so N may be rewritten mid-computation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            n_reg  <= '0;
            cnt    <= '0;
            acc    <= '0;
            result <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (we && (a == A_N)) begin
                n_reg <= wd[N_W-1:0];
            end
            case (state)
                IDLE: begin
                    if (go_req) begin
                        if (n_too_big) begin
                            err  <= 1'b1;
                            done <= 1'b0;
                        end else begin
                            err   <= 1'b0;
                            done  <= 1'b0;
                            acc   <= 32'd1;
                            cnt   <= n_reg;
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt > N_W'(1)) begin
                        acc <= acc * 32'(cnt);
                        cnt <= cnt - N_W'(1);
                    end else begin
                        result <= acc;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == BUSY);

    always_comb begin
        rd = '0;
        case (a)
            A_N:      rd = 32'(n_reg);
            A_GO:     rd = '0;
            A_STATUS: rd = {30'b0, err, done};
            A_RESULT: rd = result;
            default:  rd = '0;
        endcase
    end

endmodule

// File: tb/tb_fact_accel.sv
// Self-checking bench for fact_accel: table vectors, random n against a factorial
// model, and hand-written sequences for GO-while-busy and reset mid-computation.
module tb_fact_accel;

    localparam int N_W   = 4;
    localparam int MAX_N = 12;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we  = 1'b0;
    logic [1:0]  a   = 2'd0;
    logic [31:0] wd  = '0;
    logic [31:0] rd;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Register-level model of what software should observe
    logic [31:0] m_n;
    logic [31:0] m_result;
    logic        m_done;
    logic        m_err;

    typedef struct {
        int          n;
        logic [31:0] exp_result;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    fact_accel #(.N_W(N_W), .MAX_N(MAX_N)) dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .a    (a),
        .wd   (wd),
        .rd   (rd),
        .busy (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] fact_ref(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int k = 2; k <= n; k++) p = p * 64'(k);
        return p[31:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic readReg(input logic [1:0] off, output logic [31:0] val);
        we = 1'b0;
        a  = off;
        #1;
        val = rd;
    endtask

    // One bus write; returns 1ns after the capturing edge
    task automatic applyStimulus(input logic [1:0] off, input logic [31:0] data);
        @(negedge clk);
        we = 1'b1;
        a  = off;
        wd = data;
        @(posedge clk);
        #1;
        we = 1'b0;
        wd = '0;
    endtask

    task automatic pollDone(input int start_edges, output int edges);
        logic [31:0] v;
        logic        seen;
        edges = start_edges;
        seen  = 1'b0;
        while (!seen && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            readReg(2'd2, v);
            if (v[0]) seen = 1'b1;
        end
    endtask

    task automatic checkAllZero(input string tag);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            readReg(2'(i), v);
            checkOutput($sformatf("%s rd[%0d]", tag, i), v, 32'h0);
        end
        checkOutput({tag, " busy"}, 32'(busy), 32'h0);
    endtask

    task automatic runFactorial(input int n, input string tag);
        logic [31:0] v;
        int          edges;
        int          exp_lat;
        applyStimulus(2'd0, 32'(n));
        m_n = 32'(n) & 32'((1 << N_W) - 1);
        readReg(2'd0, v);
        checkOutput({tag, " N readback"}, v, m_n);
        applyStimulus(2'd1, 32'h1);
        if (m_n > 32'(MAX_N)) begin
            m_err  = 1'b1;
            m_done = 1'b0;
            for (int i = 0; i < 3; i++) begin
                checkOutput({tag, " busy stays low"}, 32'(busy), 32'h0);
                @(posedge clk);
                #1;
            end
        end else begin
            checkOutput({tag, " busy after GO"}, 32'(busy), 32'h1);
            pollDone(0, edges);
            exp_lat  = (m_n > 1) ? int'(m_n) : 1;
            checkOutput({tag, " latency"}, 32'(edges), 32'(exp_lat));
            m_err    = 1'b0;
            m_done   = 1'b1;
            m_result = fact_ref(int'(m_n));
            checkOutput({tag, " busy after done"}, 32'(busy), 32'h0);
        end
        readReg(2'd2, v);
        checkOutput({tag, " STATUS"}, v, {30'b0, m_err, m_done});
        readReg(2'd3, v);
        checkOutput({tag, " RESULT"}, v, m_result);
    endtask

    initial begin
        logic [31:0] v;
        int          edges;
        int          rn;

        vecs[0] = '{5,  32'h0000_0078, 1'b0};
        vecs[1] = '{0,  32'h0000_0001, 1'b0};
        vecs[2] = '{1,  32'h0000_0001, 1'b0};
        vecs[3] = '{12, 32'h1C8C_FC00, 1'b0};
        vecs[4] = '{13, 32'h1C8C_FC00, 1'b1};
        vecs[5] = '{3,  32'h0000_0006, 1'b0};
        vecs[6] = '{15, 32'h0000_0006, 1'b1};
        vecs[7] = '{7,  32'h0000_13B0, 1'b0};

        m_n = '0; m_result = '0; m_done = 1'b0; m_err = 1'b0;

        rst = 1'b0;
        #3;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkAllZero("after reset");

        for (int i = 0; i < 8; i++) begin
            runFactorial(vecs[i].n, $sformatf("vec%0d", i));
            readReg(2'd3, v);
            checkOutput($sformatf("vec%0d table RESULT", i), v, vecs[i].exp_result);
            readReg(2'd2, v);
            checkOutput($sformatf("vec%0d table err", i), 32'(v[1]), 32'(vecs[i].exp_err));
        end

        // GO with wd[0]=0 and writes to read-only offsets must change nothing
        applyStimulus(2'd1, 32'h0000_0002);
        checkOutput("GO bit0 clear busy", 32'(busy), 32'h0);
        applyStimulus(2'd2, 32'hFFFF_FFFF);
        applyStimulus(2'd3, 32'hDEAD_BEEF);
        readReg(2'd2, v);
        checkOutput("ro write STATUS", v, {30'b0, m_err, m_done});
        readReg(2'd3, v);
        checkOutput("ro write RESULT", v, m_result);
        readReg(2'd1, v);
        checkOutput("GO reads zero", v, 32'h0);

        for (int i = 0; i < 20; i++) begin
            rn = int'($urandom_range(0, 15));
            runFactorial(rn, $sformatf("rand%0d n=%0d", i, rn));
        end

        // GO while busy is ignored; N write while busy only updates n_reg
        applyStimulus(2'd0, 32'd6);
        applyStimulus(2'd1, 32'h1);
        applyStimulus(2'd0, 32'd3);
        applyStimulus(2'd1, 32'h1);
        checkOutput("busy-GO still busy", 32'(busy), 32'h1);
        pollDone(2, edges);
        checkOutput("busy-GO latency", 32'(edges), 32'd6);
        readReg(2'd3, v);
        checkOutput("busy-GO RESULT", v, 32'h0000_02D0);
        readReg(2'd0, v);
        checkOutput("busy-GO N readback", v, 32'd3);
        applyStimulus(2'd1, 32'h1);
        pollDone(0, edges);
        checkOutput("follow-up latency", 32'(edges), 32'd3);
        readReg(2'd3, v);
        checkOutput("follow-up RESULT", v, 32'h0000_0006);

        // Reset asserted in the middle of a computation
        applyStimulus(2'd0, 32'd7);
        applyStimulus(2'd1, 32'h1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkAllZero("mid-busy reset");
        @(negedge clk);
        rst = 1'b1;
        m_n = '0; m_result = '0; m_done = 1'b0; m_err = 1'b0;
        @(posedge clk);
        #1;
        checkAllZero("post reset");
        runFactorial(4, "after reset n=4");
        readReg(2'd3, v);
        checkOutput("after reset RESULT", v, 32'h0000_0018);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
